// File: rtl/fm_phase_inc_gen.sv
// ----------------------------------------------------------------------------
// fm_phase_inc_gen
//
// Purpose
//    Produces the per-sample frequency control word for the FM carrier DDS:
//       phase_inc = clamp(carrier_inc + ((mod_sample * depth) >>> SHIFT))
//    The result is clamped to the unsigned INC_W range and never wraps.
//    Carrier/depth updates arrive through a valid/ready port into a shadow
//    pair. The pair is promoted to the active pair on the next modulator
//    sample, so every sample sees a consistent carrier/depth pair.
//
// Ports
//    clk              system clock
//    reset_n          asynchronous active-low reset (synchronous release
//                     is expected from the reset source)
//    cfg_valid        config word valid
//    cfg_ready        shadow register free (no config pending)
//    cfg_carrier_inc  new carrier increment, unsigned, INC_W bits
//    cfg_depth        new modulation depth, unsigned, DEPTH_W bits
//    mod_valid        one-cycle strobe qualifying mod_sample
//    mod_sample       modulator sample, two's complement, MOD_W bits
//    sat_clr          clears sat_flag (a same-cycle clamp wins)
//    phase_inc        frequency control word, held between updates
//    phase_inc_valid  one-cycle pulse per sample, 3 cycles after mod_valid
//    sat_flag         sticky: a clamp has occurred
// ----------------------------------------------------------------------------
module fm_phase_inc_gen #(
   parameter int INC_W   = 32,
   parameter int MOD_W   = 12,
   parameter int DEPTH_W = 16,
   parameter int SHIFT   = 12
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [INC_W-1:0]   cfg_carrier_inc,
   input  logic [DEPTH_W-1:0] cfg_depth,
   input  logic               mod_valid,
   input  logic [MOD_W-1:0]   mod_sample,
   input  logic               sat_clr,
   output logic [INC_W-1:0]   phase_inc,
   output logic               phase_inc_valid,
   output logic               sat_flag
);

   // Product of a signed sample and a zero-extended (hence positive) depth.
   localparam int PROD_W = MOD_W + DEPTH_W + 1;
   // The sum needs room for the full carrier, a sign bit and one carry bit,
   // and must also hold the shifted product when that is the wider operand.
   localparam int SUM_W  = (INC_W + 2 > PROD_W + 1) ? INC_W + 2 : PROD_W + 1;

   // ------------------------------------------------------------------
   // Config shadow / active pair
   // ------------------------------------------------------------------
   logic               pending_q,        pending_d;
   logic [INC_W-1:0]   shadow_carrier_q, shadow_carrier_d;
   logic [DEPTH_W-1:0] shadow_depth_q,   shadow_depth_d;
   logic [INC_W-1:0]   active_carrier_q, active_carrier_d;
   logic [DEPTH_W-1:0] active_depth_q,   active_depth_d;

   logic               cfg_accept;
   logic               cfg_apply;
   logic [INC_W-1:0]   sel_carrier;
   logic [DEPTH_W-1:0] sel_depth;

   // ------------------------------------------------------------------
   // Pipeline registers
   // ------------------------------------------------------------------
   logic                     s0_valid_q,   s0_valid_d;
   logic [MOD_W-1:0]         s0_sample_q,  s0_sample_d;
   logic [INC_W-1:0]         s0_carrier_q, s0_carrier_d;
   logic [DEPTH_W-1:0]       s0_depth_q,   s0_depth_d;

   logic                     s1_valid_q,   s1_valid_d;
   logic signed [PROD_W-1:0] s1_prod_q,    s1_prod_d;
   logic [INC_W-1:0]         s1_carrier_q, s1_carrier_d;

   logic [INC_W-1:0]         phase_inc_q,       phase_inc_d;
   logic                     phase_inc_valid_q, phase_inc_valid_d;
   logic                     sat_flag_q,        sat_flag_d;

   // S2 datapath
   logic signed [PROD_W-1:0] off_s;
   logic signed [SUM_W-1:0]  off_ext;
   logic signed [SUM_W-1:0]  car_ext;
   logic signed [SUM_W-1:0]  sum_s;
   logic                     clamp_lo;
   logic                     clamp_hi;
   logic [INC_W-1:0]         clamped;

   // ------------------------------------------------------------------
   // Config handshake and apply
   // ------------------------------------------------------------------
   // Accept and apply are mutually exclusive: accept needs an empty
   // shadow, apply needs a full one. A config accepted alongside a sample
   // therefore only reaches the following sample.
   always_comb begin
      cfg_accept = cfg_valid && !pending_q;
      cfg_apply  = mod_valid && pending_q;

      pending_d        = pending_q;
      shadow_carrier_d = shadow_carrier_q;
      shadow_depth_d   = shadow_depth_q;
      active_carrier_d = active_carrier_q;
      active_depth_d   = active_depth_q;

      if (cfg_apply) begin
         active_carrier_d = shadow_carrier_q;
         active_depth_d   = shadow_depth_q;
         pending_d        = 1'b0;
      end

      if (cfg_accept) begin
         shadow_carrier_d = cfg_carrier_inc;
         shadow_depth_d   = cfg_depth;
         pending_d        = 1'b1;
      end

      // The sample that performs the apply already uses the new pair.
      sel_carrier = pending_q ? shadow_carrier_q : active_carrier_q;
      sel_depth   = pending_q ? shadow_depth_q   : active_depth_q;
   end

   assign cfg_ready = !pending_q;

   // ------------------------------------------------------------------
   // S0: capture sample together with its carrier/depth pair
   // ------------------------------------------------------------------
   always_comb begin
      s0_valid_d   = mod_valid;
      s0_sample_d  = s0_sample_q;
      s0_carrier_d = s0_carrier_q;
      s0_depth_d   = s0_depth_q;
      if (mod_valid) begin
         s0_sample_d  = mod_sample;
         s0_carrier_d = sel_carrier;
         s0_depth_d   = sel_depth;
      end
   end

   // ------------------------------------------------------------------
   // S1: signed multiply, carrier travels alongside
   // ------------------------------------------------------------------
   always_comb begin
      s1_valid_d   = s0_valid_q;
      s1_prod_d    = s1_prod_q;
      s1_carrier_d = s1_carrier_q;
      if (s0_valid_q) begin
         s1_prod_d    = PROD_W'($signed(s0_sample_q)) *
                        PROD_W'($signed({1'b0, s0_depth_q}));
         s1_carrier_d = s0_carrier_q;
      end
   end

   // ------------------------------------------------------------------
   // S2: shift, add, clamp
   // ------------------------------------------------------------------
   always_comb begin
      // Arithmetic shift floors toward -inf, so small negative products
      // give -1 rather than 0.
      off_s   = s1_prod_q >>> SHIFT;
      off_ext = SUM_W'(off_s);
      car_ext = $signed({{(SUM_W - INC_W){1'b0}}, s1_carrier_q});
      sum_s   = car_ext + off_ext;

      clamp_lo = sum_s[SUM_W-1];
      clamp_hi = !sum_s[SUM_W-1] && (|sum_s[SUM_W-2:INC_W]);

      if (clamp_lo) begin
         clamped = '0;
      end else if (clamp_hi) begin
         clamped = '1;
      end else begin
         clamped = sum_s[INC_W-1:0];
      end

      phase_inc_valid_d = s1_valid_q;
      phase_inc_d       = s1_valid_q ? clamped : phase_inc_q;

      // A clamp in the same cycle as sat_clr keeps the flag set.
      if (s1_valid_q && (clamp_lo || clamp_hi)) begin
         sat_flag_d = 1'b1;
      end else if (sat_clr) begin
         sat_flag_d = 1'b0;
      end else begin
         sat_flag_d = sat_flag_q;
      end
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q         <= 1'b0;
         shadow_carrier_q  <= '0;
         shadow_depth_q    <= '0;
         active_carrier_q  <= '0;
         active_depth_q    <= '0;
         s0_valid_q        <= 1'b0;
         s0_sample_q       <= '0;
         s0_carrier_q      <= '0;
         s0_depth_q        <= '0;
         s1_valid_q        <= 1'b0;
         s1_prod_q         <= '0;
         s1_carrier_q      <= '0;
         phase_inc_q       <= '0;
         phase_inc_valid_q <= 1'b0;
         sat_flag_q        <= 1'b0;
      end else begin
         pending_q         <= pending_d;
         shadow_carrier_q  <= shadow_carrier_d;
         shadow_depth_q    <= shadow_depth_d;
         active_carrier_q  <= active_carrier_d;
         active_depth_q    <= active_depth_d;
         s0_valid_q        <= s0_valid_d;
         s0_sample_q       <= s0_sample_d;
         s0_carrier_q      <= s0_carrier_d;
         s0_depth_q        <= s0_depth_d;
         s1_valid_q        <= s1_valid_d;
         s1_prod_q         <= s1_prod_d;
         s1_carrier_q      <= s1_carrier_d;
         phase_inc_q       <= phase_inc_d;
         phase_inc_valid_q <= phase_inc_valid_d;
         sat_flag_q        <= sat_flag_d;
      end
   end

   assign phase_inc       = phase_inc_q;
   assign phase_inc_valid = phase_inc_valid_q;
   assign sat_flag        = sat_flag_q;

endmodule

// File: tb/tb_fm_phase_inc_gen.sv
// ----------------------------------------------------------------------------
// tb_fm_phase_inc_gen
//
// Bench for fm_phase_inc_gen. A behavioural model computes each output word
// with plain integer arithmetic and delays it by the documented latency; a
// compare process checks every DUT output against it on every falling edge.
// Directed sequences add hand-computed literal expectations on top.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_fm_phase_inc_gen;

   localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_carrier_inc;
   logic [15:0] cfg_depth;
   logic        mod_valid;
   logic [11:0] mod_sample;
   logic        sat_clr;
   logic [31:0] phase_inc;
   logic        phase_inc_valid;
   logic        sat_flag;

   int checks = 0;
   int errors = 0;

   fm_phase_inc_gen #(
      .INC_W   (32),
      .MOD_W   (12),
      .DEPTH_W (16),
      .SHIFT   (12)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_carrier_inc (cfg_carrier_inc),
      .cfg_depth       (cfg_depth),
      .mod_valid       (mod_valid),
      .mod_sample      (mod_sample),
      .sat_clr         (sat_clr),
      .phase_inc       (phase_inc),
      .phase_inc_valid (phase_inc_valid),
      .sat_flag        (sat_flag)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Offers a config word until it is taken (bounded wait).
   task automatic do_cfg(input logic [31:0] car, input logic [15:0] dep);
      bit ok;
      ok              = 1'b0;
      cfg_valid       = 1'b1;
      cfg_carrier_inc = car;
      cfg_depth       = dep;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (cfg_ready) ok = 1'b1;
         @(negedge clk);
      end
      cfg_valid = 1'b0;
      check("cfg_accept", 64'(ok), 64'd1);
   endtask

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   function automatic logic [31:0] model_inc(input longint car, input longint dep,
                                             input longint smp, output bit clamp);
      longint sum;
      sum   = car + ((smp * dep) >>> 12);
      clamp = 1'b0;
      if (sum < 0) begin
         clamp = 1'b1;
         return 32'd0;
      end
      if (sum > MAXV) begin
         clamp = 1'b1;
         return 32'hFFFF_FFFF;
      end
      return sum[31:0];
   endfunction

   bit          m_pending = 0;
   longint      m_sh_car  = 0;
   longint      m_sh_dep  = 0;
   longint      m_act_car = 0;
   longint      m_act_dep = 0;
   bit          dv0 = 0, dv1 = 0, dc0 = 0, dc1 = 0;
   logic [31:0] di0 = '0, di1 = '0;
   bit          m_valid = 0;
   logic [31:0] m_inc = '0;
   bit          m_sat = 0;
   bit          m_p;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_pending = 0; m_sh_car = 0; m_sh_dep = 0; m_act_car = 0; m_act_dep = 0;
         dv0 = 0; dv1 = 0; dc0 = 0; dc1 = 0; di0 = '0; di1 = '0;
         m_valid = 0; m_inc = '0; m_sat = 0;
      end else begin
         m_p = m_pending;
         // Word computed two edges ago becomes visible now.
         m_valid = dv1;
         if (dv1) m_inc = di1;
         if (dv1 && dc1) m_sat = 1;
         else if (sat_clr) m_sat = 0;
         dv1 = dv0; di1 = di0; dc1 = dc0;
         dv0 = mod_valid;
         if (mod_valid) begin
            if (m_p) begin
               m_act_car = m_sh_car;
               m_act_dep = m_sh_dep;
               m_pending = 0;
            end
            di0 = model_inc(m_act_car, m_act_dep, longint'($signed(mod_sample)), dc0);
         end
         if (cfg_valid && !m_p) begin
            m_sh_car  = longint'(cfg_carrier_inc);
            m_sh_dep  = longint'(cfg_depth);
            m_pending = 1;
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_phase_inc",       64'(phase_inc),       64'(m_inc));
      check("cmp_phase_inc_valid", 64'(phase_inc_valid), 64'(m_valid));
      check("cmp_sat_flag",        64'(sat_flag),        64'(m_sat));
      check("cmp_cfg_ready",       64'(cfg_ready),       64'(!m_pending));
   end

   // ------------------------------------------------------------------
   // Vector table: {carrier, depth, four back-to-back samples}
   // ------------------------------------------------------------------
   logic [31:0] tv_car [4] = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
   logic [15:0] tv_dep [4] = '{16'hFFFF,      16'h0001,      16'h1000,      16'h0800};
   logic [11:0] tv_smp [4][4] = '{'{12'h7FF, 12'h800, 12'h001, 12'hFFF},
                                 '{12'hFFF, 12'h7FF, 12'h800, 12'h000},
                                 '{12'h001, 12'hFFF, 12'h7FF, 12'h800},
                                 '{12'h123, 12'hEDC, 12'h400, 12'hC00}};

   // ------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------
   initial begin
      reset_n = 1'b0; cfg_valid = 1'b0; cfg_carrier_inc = '0; cfg_depth = '0;
      mod_valid = 1'b0; mod_sample = '0; sat_clr = 1'b0;
      tick(2);
      check("rst_phase_inc", 64'(phase_inc), 64'd0);
      check("rst_valid",     64'(phase_inc_valid), 64'd0);
      check("rst_sat",       64'(sat_flag), 64'd0);
      check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      reset_n = 1'b1;
      tick(2);

      // T1: depth 0 passes the carrier through unchanged
      do_cfg(32'h0100_0000, 16'd0);
      check("t1_ready_low", 64'(cfg_ready), 64'd0);
      mod_valid = 1'b1; mod_sample = 12'h7FF;
      tick(1); mod_valid = 1'b0;
      tick(1);
      check("t1_no_early_valid", 64'(phase_inc_valid), 64'd0);
      tick(1);
      check("t1_phase_inc", 64'(phase_inc), 64'h0100_0000);
      check("t1_valid",     64'(phase_inc_valid), 64'd1);
      tick(1);
      check("t1_valid_drop", 64'(phase_inc_valid), 64'd0);
      check("t1_hold",       64'(phase_inc), 64'h0100_0000);

      // T2: back-to-back samples, positive and negative full scale
      do_cfg(32'h0100_0000, 16'd4096);
      mod_valid = 1'b1; mod_sample = 12'h7FF;
      tick(1); mod_sample = 12'h800;
      tick(1); mod_valid = 1'b0;
      tick(1);
      check("t2_pos", 64'(phase_inc), 64'h0100_07FF);
      check("t2_pos_valid", 64'(phase_inc_valid), 64'd1);
      tick(1);
      check("t2_neg", 64'(phase_inc), 64'h00FF_F800);
      check("t2_neg_valid", 64'(phase_inc_valid), 64'd1);
      tick(1);

      // T3: clamp high, clear, clamp low
      do_cfg(32'hFFFF_FF00, 16'hFFFF);
      mod_valid = 1'b1; mod_sample = 12'h7FF;
      tick(1); mod_valid = 1'b0;
      tick(2);
      check("t3_clamp_hi", 64'(phase_inc), 64'hFFFF_FFFF);
      check("t3_sat_hi",   64'(sat_flag), 64'd1);
      sat_clr = 1'b1;
      tick(1); sat_clr = 1'b0;
      check("t3_sat_clr", 64'(sat_flag), 64'd0);
      do_cfg(32'h0000_0010, 16'd4096);
      mod_valid = 1'b1; mod_sample = 12'h800;
      tick(1); mod_valid = 1'b0;
      tick(2);
      check("t3_clamp_lo", 64'(phase_inc), 64'd0);
      check("t3_sat_lo",   64'(sat_flag), 64'd1);

      // T4: config accepted together with a sample reaches only the next one
      check("t4_ready_idle", 64'(cfg_ready), 64'd1);
      cfg_valid = 1'b1; cfg_carrier_inc = 32'h2000_0000; cfg_depth = 16'd0;
      mod_valid = 1'b1; mod_sample = 12'd100;
      tick(1); cfg_valid = 1'b0; mod_valid = 1'b0;
      check("t4_ready_low", 64'(cfg_ready), 64'd0);
      tick(2);
      check("t4_old_pair", 64'(phase_inc), 64'h0000_0074);
      check("t4_ready_still_low", 64'(cfg_ready), 64'd0);
      mod_valid = 1'b1; mod_sample = 12'd5;
      tick(1); mod_valid = 1'b0;
      check("t4_ready_back", 64'(cfg_ready), 64'd1);
      tick(2);
      check("t4_new_pair", 64'(phase_inc), 64'h2000_0000);

      // T6: shift floors toward -inf
      do_cfg(32'h0000_0100, 16'd1);
      mod_valid = 1'b1; mod_sample = 12'hFFF;
      tick(1); mod_sample = 12'h7FF;
      tick(1); mod_valid = 1'b0;
      tick(1);
      check("t6_floor_neg", 64'(phase_inc), 64'h0000_00FF);
      tick(1);
      check("t6_floor_pos", 64'(phase_inc), 64'h0000_0100);

      // Vector table, checked by the model only
      for (int v = 0; v < 4; v++) begin
         do_cfg(tv_car[v], tv_dep[v]);
         for (int s = 0; s < 4; s++) begin
            mod_valid = 1'b1; mod_sample = tv_smp[v][s];
            tick(1);
         end
         mod_valid = 1'b0;
         tick(4);
      end

      // T5: reset mid-operation drops in-flight data and the pending config
      do_cfg(32'h3000_0000, 16'd0);
      mod_valid = 1'b1; mod_sample = 12'd5;
      tick(1); mod_valid = 1'b0;
      do_cfg(32'h4000_0000, 16'd0);
      #2 reset_n = 1'b0;
      #1;
      check("t5_rst_phase_inc", 64'(phase_inc), 64'd0);
      check("t5_rst_valid",     64'(phase_inc_valid), 64'd0);
      check("t5_rst_sat",       64'(sat_flag), 64'd0);
      check("t5_rst_ready",     64'(cfg_ready), 64'd1);
      tick(2);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         check("t5_no_valid", 64'(phase_inc_valid), 64'd0);
      end
      check("t5_ready_after", 64'(cfg_ready), 64'd1);
      mod_valid = 1'b1; mod_sample = 12'h7FF;
      tick(1); mod_valid = 1'b0;
      tick(2);
      check("t5_pending_lost", 64'(phase_inc), 64'd0);
      check("t5_valid_after",  64'(phase_inc_valid), 64'd1);
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
